// File: rtl/scope_capture_reader.sv
// Oscilloscope capture engine: drains ADC samples from the sample FIFO, runs a
// level/slope trigger with auto-timeout, and writes one frame to the frame buffer.
module scope_capture_reader #(
    parameter int unsigned SAMPLE_W     = 12,
    parameter int unsigned FRAME_LEN    = 256,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned AUTO_TIMEOUT = 1000000,
    parameter int unsigned TMR_W        = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                frame_ack,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic                auto_en,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_data,
    output logic                fifo_rd,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [SAMPLE_W-1:0] fb_data,
    output logic                busy,
    output logic                frame_done,
    output logic                auto_trig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   ISSUE_MAX = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [TMR_W-1:0]  TIMEOUT   = TMR_W'(AUTO_TIMEOUT);

    state_t                state_q, state_d;
    logic                  rd_q;
    logic [SAMPLE_W-1:0]   prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ADDR_W:0]       issued_q, issued_d;
    logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                  auto_q, auto_d;
    logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
    logic [SAMPLE_W-1:0]   fb_data_q, fb_data_d;

    logic                  want_rd;
    logic                  rd_en;
    logic                  level_hit;
    logic                  force_hit;
    logic                  trig;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  last_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            timer_q    <= '0;
            issued_q   <= '0;
            wr_cnt_q   <= '0;
            auto_q     <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_en;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            timer_q    <= timer_d;
            issued_q   <= issued_d;
            wr_cnt_q   <= wr_cnt_d;
            auto_q     <= auto_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    // rd_q marks the cycle in which fifo_data carries a freshly read sample.
    always_comb begin
        level_hit = 1'b0;
        if (prev_vld_q) begin
            if (trig_falling) begin
                level_hit = (prev_q > trig_level) && (fifo_data <= trig_level);
            end else begin
                level_hit = (prev_q < trig_level) && (fifo_data >= trig_level);
            end
        end
        force_hit = auto_en && (timer_q >= TIMEOUT);
        trig      = (state_q == S_WAIT_TRIG) && rd_q && (level_hit || force_hit);
        wr_en     = trig || ((state_q == S_CAPTURE) && rd_q);
        wr_addr   = trig ? '0 : wr_cnt_q;
        last_wr   = wr_en && (wr_addr == LAST_ADDR);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (arm) state_d = S_WAIT_TRIG;
            S_WAIT_TRIG: if (trig) state_d = last_wr ? S_DONE : S_CAPTURE;
            S_CAPTURE:   if (last_wr) state_d = S_DONE;
            S_DONE:      if (frame_ack) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        timer_d    = timer_q;
        issued_d   = issued_q;
        wr_cnt_d   = wr_cnt_q;
        auto_d     = auto_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    timer_d    = '0;
                    prev_vld_d = 1'b0;
                    auto_d     = 1'b0;
                end
            end
            S_WAIT_TRIG: begin
                if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
                if (rd_q) begin
                    prev_d     = fifo_data;
                    prev_vld_d = 1'b1;
                end
                // The trigger sample plus any read issued this same cycle count as issued.
                if (trig) begin
                    auto_d   = !level_hit;
                    issued_d = rd_en ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1);
                    wr_cnt_d = ADDR_W'(1);
                end
            end
            S_CAPTURE: begin
                if (rd_en) issued_d = issued_q + (ADDR_W + 1)'(1);
                if (rd_q)  wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end
            default: ;
        endcase
        if (wr_en) begin
            fb_addr_d = wr_addr;
            fb_data_d = fifo_data;
        end
    end

    always_comb begin
        want_rd = 1'b0;
        case (state_q)
            S_WAIT_TRIG: want_rd = 1'b1;
            S_CAPTURE:   want_rd = (issued_q < ISSUE_MAX);
            default:     want_rd = 1'b0;
        endcase
        rd_en      = want_rd && !fifo_empty && !rst;
        fifo_rd    = rd_en;
        fb_we      = wr_en && !rst;
        fb_addr    = rst ? '0 : (wr_en ? wr_addr : fb_addr_q);
        fb_data    = rst ? '0 : (wr_en ? fifo_data : fb_data_q);
        busy       = !rst && ((state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE));
        frame_done = !rst && (state_q == S_DONE);
        auto_trig  = !rst && auto_q;
    end

endmodule

// File: tb/tb_scope_capture_reader.sv
// Directed bench for scope_capture_reader: behavioural FIFO with optional gaps,
// frame-buffer write logger, and one task per scenario.
module tb_scope_capture_reader;

    localparam int STIM_DEPTH = 4096;
    localparam int LOG_DEPTH  = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        frame_ack = 1'b0;
    logic [11:0] trig_level = '0;
    logic        trig_falling = 1'b0;
    logic        auto_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [11:0] fifo_data = '0;
    logic        fifo_rd;
    logic        fb_we;
    logic [7:0]  fb_addr;
    logic [11:0] fb_data;
    logic        busy;
    logic        frame_done;
    logic        auto_trig;

    int n_pass = 0;
    int n_total = 0;

    scope_capture_reader #(
        .SAMPLE_W(12),
        .FRAME_LEN(256),
        .ADDR_W(8),
        .AUTO_TIMEOUT(64),
        .TMR_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .frame_ack(frame_ack),
        .trig_level(trig_level),
        .trig_falling(trig_falling),
        .auto_en(auto_en),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd(fifo_rd),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .busy(busy),
        .frame_done(frame_done),
        .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus source written by tasks; FIFO model moves one word per cycle into fifo_q.
    logic [11:0] stim [0:STIM_DEPTH-1];
    int          stim_n = 0;
    int          flush_req = 0;
    bit          bursty = 1'b0;

    logic [11:0] fifo_q [$];
    int          stim_rd = 0;
    int          flush_ack = 0;
    int          gap = 0;
    int          fifo_level = 0;

    always @(posedge clk) begin
        if (flush_req != flush_ack) begin
            fifo_q.delete();
            stim_rd   = stim_n;
            flush_ack = flush_req;
            gap       = 0;
        end
        if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        if (gap > 0) begin
            gap = gap - 1;
        end else if (stim_rd < stim_n) begin
            fifo_q.push_back(stim[stim_rd % STIM_DEPTH]);
            stim_rd = stim_rd + 1;
            gap = bursty ? int'($urandom_range(5, 0)) : 0;
        end
        fifo_empty <= (fifo_q.size() == 0);
        fifo_level <= (stim_n - stim_rd) + fifo_q.size();
    end

    logic [7:0]  log_addr [0:LOG_DEPTH-1];
    logic [11:0] log_data [0:LOG_DEPTH-1];
    int          log_cyc  [0:LOG_DEPTH-1];
    int          wr_count = 0;
    int          rd_count = 0;
    int          viol_count = 0;
    int          done_cyc = 0;
    bit          done_prev = 1'b0;

    always @(negedge clk) begin
        if (fb_we && wr_count < LOG_DEPTH) begin
            log_addr[wr_count] = fb_addr;
            log_data[wr_count] = fb_data;
            log_cyc[wr_count]  = cyc;
            wr_count = wr_count + 1;
        end
        if (fifo_rd) rd_count = rd_count + 1;
        if (fifo_rd && fifo_empty) viol_count = viol_count + 1;
        if (frame_done && !done_prev) done_cyc = cyc;
        done_prev = frame_done;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic flush();
        flush_req = flush_req + 1;
        step(3);
    endtask

    task automatic load_ramp(input logic [11:0] start, input logic [11:0] stp, input int n);
        logic [11:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            stim[(stim_n + i) % STIM_DEPTH] = v;
            v = v + stp;
        end
        stim_n = stim_n + n;
    endtask

    task automatic pulse_arm(output int t0);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        t0 = cyc;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    function automatic int frame_errs(input int base, input logic [11:0] start,
                                      input logic [11:0] stp, output int first);
        logic [11:0] e;
        int n;
        n = 0;
        first = -1;
        e = start;
        for (int i = 0; i < 256; i++) begin
            if (log_addr[(base + i) % LOG_DEPTH] !== 8'(i) || log_data[(base + i) % LOG_DEPTH] !== e) begin
                n = n + 1;
                if (first < 0) first = i;
            end
            e = e + stp;
        end
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_total++;
        if ({fifo_rd, fb_we, fb_addr, fb_data, busy, frame_done, auto_trig} !== 25'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {fifo_rd, fb_we, fb_addr, fb_data, busy, frame_done, auto_trig});
        end else n_pass++;
        rst = 1'b0;
        step(2);
        n_total++;
        if ({busy, frame_done} !== 2'b00) $display("FAIL reset_idle: busy/done got %b expected 00", {busy, frame_done});
        else n_pass++;
    endtask

    task automatic test_rising();
        int base, rd0, t0, errs, first;
        bit ok;
        trig_level = 12'h800; trig_falling = 1'b0; auto_en = 1'b0; bursty = 1'b0;
        flush();
        load_ramp(12'h000, 12'h010, 394);
        step(5);
        base = wr_count; rd0 = rd_count;
        pulse_arm(t0);
        wait_done(3000, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL rising_done: frame_done not seen within budget");
        else n_pass++;
        n_total++;
        if ((wr_count - base) !== 256) $display("FAIL rising_count: got %0d writes expected 256", wr_count - base);
        else n_pass++;
        n_total++;
        if ({log_addr[base], log_data[base]} !== {8'h00, 12'h800})
            $display("FAIL rising_first: got addr %h data %h expected addr 00 data 800", log_addr[base], log_data[base]);
        else n_pass++;
        errs = frame_errs(base, 12'h800, 12'h010, first);
        n_total++;
        if (errs !== 0) $display("FAIL rising_frame: %0d bad entries, first at %0d expected 0 bad", errs, first);
        else n_pass++;
        n_total++;
        if (done_cyc !== log_cyc[base + 255] + 1)
            $display("FAIL rising_done_timing: done at cycle %0d expected %0d", done_cyc, log_cyc[base + 255] + 1);
        else n_pass++;
        n_total++;
        if (auto_trig !== 1'b0) $display("FAIL rising_auto: got %b expected 0", auto_trig);
        else n_pass++;
        n_total++;
        if ((rd_count - rd0) !== 384) $display("FAIL rising_reads: got %0d expected 384", rd_count - rd0);
        else n_pass++;
        step(20);
        n_total++;
        if (fifo_level !== 10) $display("FAIL rising_leftover: got %0d expected 10", fifo_level);
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_falling();
        int base, rd0, t0, errs, first;
        bit ok;
        trig_level = 12'h400; trig_falling = 1'b1; auto_en = 1'b0; bursty = 1'b0;
        // A ramp that starts at the level must not fire on its first sample.
        flush();
        load_ramp(12'h400, 12'hFF0, 20);
        step(5);
        base = wr_count; rd0 = rd_count;
        pulse_arm(t0);
        step(40);
        n_total++;
        if ((wr_count - base) !== 0) $display("FAIL falling_first_sample: got %0d writes expected 0", wr_count - base);
        else n_pass++;
        n_total++;
        if ({busy, (rd_count - rd0) == 20} !== 2'b11)
            $display("FAIL falling_first_wait: busy %b reads %0d expected busy 1 reads 20", busy, rd_count - rd0);
        else n_pass++;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);

        flush();
        load_ramp(12'hFF0, 12'hFF0, 457);
        step(5);
        base = wr_count;
        pulse_arm(t0);
        wait_done(3000, ok);
        n_total++;
        if ({log_addr[base], log_data[base]} !== {8'h00, 12'h400})
            $display("FAIL falling_first: got addr %h data %h expected addr 00 data 400", log_addr[base], log_data[base]);
        else n_pass++;
        errs = frame_errs(base, 12'h400, 12'hFF0, first);
        n_total++;
        if (ok !== 1'b1 || errs !== 0)
            $display("FAIL falling_frame: done %b, %0d bad entries (first %0d) expected done 1, 0 bad", ok, errs, first);
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_auto();
        int base, t0, errs, first;
        bit ok;
        trig_level = 12'h800; trig_falling = 1'b0; auto_en = 1'b1; bursty = 1'b0;
        flush();
        load_ramp(12'h100, 12'h000, 400);
        step(5);
        base = wr_count;
        pulse_arm(t0);
        wait_done(3000, ok);
        n_total++;
        if (log_cyc[base] !== t0 + 64)
            $display("FAIL auto_timing: trigger at WAIT cycle %0d expected 64", log_cyc[base] - t0);
        else n_pass++;
        n_total++;
        if ({log_addr[base], log_data[base]} !== {8'h00, 12'h100})
            $display("FAIL auto_first: got addr %h data %h expected addr 00 data 100", log_addr[base], log_data[base]);
        else n_pass++;
        errs = frame_errs(base, 12'h100, 12'h000, first);
        n_total++;
        if (ok !== 1'b1 || errs !== 0 || (wr_count - base) !== 256)
            $display("FAIL auto_frame: done %b bad %0d writes %0d expected done 1 bad 0 writes 256",
                     ok, errs, wr_count - base);
        else n_pass++;
        n_total++;
        if ({frame_done, auto_trig} !== 2'b11) $display("FAIL auto_flag: done/auto got %b expected 11", {frame_done, auto_trig});
        else n_pass++;
        pulse_ack();
        auto_en = 1'b0;
    endtask

    task automatic test_bursty();
        int base, rd0, t0, errs, first, viol0;
        bit ok;
        trig_level = 12'h800; trig_falling = 1'b0; auto_en = 1'b0; bursty = 1'b1;
        flush();
        load_ramp(12'h000, 12'h010, 394);
        step(5);
        base = wr_count; rd0 = rd_count; viol0 = viol_count;
        pulse_arm(t0);
        wait_done(6000, ok);
        n_total++;
        if (ok !== 1'b1 || (wr_count - base) !== 256)
            $display("FAIL bursty_count: done %b writes %0d expected done 1 writes 256", ok, wr_count - base);
        else n_pass++;
        errs = frame_errs(base, 12'h800, 12'h010, first);
        n_total++;
        if (errs !== 0) $display("FAIL bursty_frame: %0d bad entries, first at %0d expected 0 bad", errs, first);
        else n_pass++;
        n_total++;
        if ((rd_count - rd0) !== 384) $display("FAIL bursty_reads: got %0d expected 384", rd_count - rd0);
        else n_pass++;
        n_total++;
        if (auto_trig !== 1'b0) $display("FAIL bursty_auto: got %b expected 0", auto_trig);
        else n_pass++;
        step(100);
        n_total++;
        if (fifo_level !== 10) $display("FAIL bursty_leftover: got %0d expected 10", fifo_level);
        else n_pass++;
        n_total++;
        if ((viol_count - viol0) !== 0) $display("FAIL bursty_empty_read: got %0d reads while empty expected 0", viol_count - viol0);
        else n_pass++;
        bursty = 1'b0;
        pulse_ack();
    endtask

    task automatic test_reset_mid_capture();
        int base, rd0, t0, errs, first;
        bit ok, found;
        trig_level = 12'h800; trig_falling = 1'b0; auto_en = 1'b0; bursty = 1'b0;
        flush();
        load_ramp(12'h000, 12'h010, 394);
        step(5);
        pulse_arm(t0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (fb_we && fb_addr == 8'd100) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        n_total++;
        if (found !== 1'b1) $display("FAIL midrst_reach: write at addr 100 not seen within budget");
        else n_pass++;
        rst = 1'b1;
        step(1);
        n_total++;
        if ({fifo_rd, fb_we, fb_addr, fb_data, busy, frame_done, auto_trig} !== 25'd0)
            $display("FAIL midrst_outputs: got %h expected 0",
                     {fifo_rd, fb_we, fb_addr, fb_data, busy, frame_done, auto_trig});
        else n_pass++;
        rst = 1'b0;
        step(1);
        n_total++;
        if ({busy, frame_done} !== 2'b00) $display("FAIL midrst_idle: busy/done got %b expected 00", {busy, frame_done});
        else n_pass++;
        flush();
        rd0 = rd_count;
        load_ramp(12'h000, 12'h010, 394);
        step(20);
        n_total++;
        if ((rd_count - rd0) !== 0) $display("FAIL midrst_no_arm_read: got %0d reads expected 0", rd_count - rd0);
        else n_pass++;
        base = wr_count;
        pulse_arm(t0);
        wait_done(3000, ok);
        errs = frame_errs(base, 12'h800, 12'h010, first);
        n_total++;
        if (ok !== 1'b1 || errs !== 0 || (wr_count - base) !== 256)
            $display("FAIL midrst_rearm_frame: done %b bad %0d writes %0d expected done 1 bad 0 writes 256",
                     ok, errs, wr_count - base);
        else n_pass++;
        pulse_ack();
    endtask

    task automatic test_done_handshake();
        int t0;
        bit ok;
        trig_level = 12'h800; trig_falling = 1'b0; auto_en = 1'b0; bursty = 1'b0;
        flush();
        load_ramp(12'h000, 12'h010, 394);
        step(5);
        pulse_arm(t0);
        wait_done(3000, ok);
        pulse_arm(t0);
        step(3);
        n_total++;
        if ({ok, frame_done, busy} !== 3'b110)
            $display("FAIL done_arm_ignored: done_seen/done/busy got %b expected 110", {ok, frame_done, busy});
        else n_pass++;
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL done_ack: frame_done got %b expected 0", frame_done);
        else n_pass++;
        step(1);
        pulse_arm(t0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL done_rearm: busy got %b expected 1", busy);
        else n_pass++;
        pulse_ack();
        n_total++;
        if ({busy, frame_done} !== 2'b10) $display("FAIL ack_in_wait_ignored: busy/done got %b expected 10", {busy, frame_done});
        else n_pass++;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_auto();
        test_bursty();
        test_reset_mid_capture();
        test_done_handshake();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scope_capture_reader.md
Name: scope_capture_reader

Overview:
- Drains 12-bit ADC samples from the sample FIFO (consumer side of the FIFO's write/read interface).
- Runs a level/slope trigger with an auto-trigger timeout.
- On trigger, writes one contiguous frame of samples into the display frame buffer, then holds the frame until the display side acknowledges it.

Parameters:
- SAMPLE_W, 12, sample width; matches the FIFO data width.
- FRAME_LEN, 256, samples per captured frame; must be ≤ 2^ADDR_W.
- ADDR_W, 8, frame buffer address width.
- AUTO_TIMEOUT, 1000000, clk cycles in WAIT_TRIG before a forced trigger.
- TMR_W, 20, auto-trigger timer width; must satisfy 2^TMR_W > AUTO_TIMEOUT.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts an acquisition from IDLE.
- frame_ack  in  1  one-cycle pulse from display; releases DONE.
- trig_level  in  SAMPLE_W  unsigned trigger threshold; sampled every cycle.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- auto_en  in  1  enables the auto-trigger timeout.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  SAMPLE_W  FIFO registered read data.
- fifo_rd  out  1  FIFO read strobe.
- fb_we  out  1  frame buffer write enable.
- fb_addr  out  ADDR_W  frame buffer write address.
- fb_data  out  SAMPLE_W  frame buffer write data.
- busy  out  1  high in WAIT_TRIG or CAPTURE.
- frame_done  out  1  high in DONE.
- auto_trig  out  1  current/last frame was forced by timeout; valid while frame_done is high.

Behaviour:
- Reset:
  - While rst is high all outputs are 0, including fifo_rd (gated by rst).
  - State returns to IDLE; timer, counters and the prev-sample-valid flag are cleared.
  - Reset mid-capture abandons the frame; any read already in flight is discarded.
- FIFO read timing:
  - fifo_rd is combinational: want_rd AND NOT fifo_empty.
  - It is never asserted while fifo_empty is high.
  - Read data is valid on fifo_data exactly 1 cycle after a cycle with fifo_rd=1. An internal rd_q register marks that cycle (sample valid).
  - Maximum throughput is one read per cycle.
- IDLE:
  - want_rd=0.
  - arm -> WAIT_TRIG; this clears the timer, the prev-valid flag and auto_trig.
- WAIT_TRIG:
  - want_rd=1; samples are consumed and discarded.
  - Timer increments every cycle.
  - On each valid sample cur, with prev = the previous valid sample of this acquisition:
    - rising trigger if prev < trig_level AND cur >= trig_level.
    - falling trigger if prev > trig_level AND cur <= trig_level.
    - The first valid sample after arm only loads prev; it cannot trigger.
  - Forced trigger: auto_en=1 and timer ≥ AUTO_TIMEOUT -> the next valid sample triggers and auto_trig is set to 1.
  - On trigger, in the same cycle: fb_we=1, fb_addr=0, fb_data=cur; go to CAPTURE.
  - arm is ignored in this state.
- CAPTURE:
  - issued count = trigger sample + every fifo_rd since trigger, including a read in flight at trigger time.
  - want_rd = issued < FRAME_LEN, so the block never over-reads.
  - Each valid sample is written with fb_we=1 at addresses 1, 2, … FRAME_LEN-1.
  - Addresses are contiguous regardless of FIFO empty gaps; fb_we=0 in gap cycles.
  - After the write at FRAME_LEN-1, go to DONE the next cycle.
- DONE:
  - want_rd=0; frame_done=1.
  - frame_ack -> IDLE.
  - arm is ignored in DONE.
  - frame_ack is ignored in all other states.
- Comparisons are unsigned, at full SAMPLE_W width.
- fb_addr and fb_data hold their last values when fb_we=0.

Test Plan:
- Rising trigger:
  - Setup: rst; arm; FIFO fed a ramp 0x000, 0x010, …, trig_level=0x800, trig_falling=0.
  - Required: first write is addr 0 = 0x800, then addr 1 = 0x810 … addr 255 = 0x17F0 wrapped per ramp; frame_done=1 one cycle after the addr-255 write; auto_trig=0.
- Falling trigger:
  - Setup: descending ramp from 0xFF0 step -0x10, level 0x400, trig_falling=1.
  - Required: addr 0 = 0x400.
  - Also: a ramp starting at exactly 0x400 does not trigger on its first sample.
- Auto trigger:
  - Setup: AUTO_TIMEOUT=64, auto_en=1, constant 0x100, level 0x800.
  - Required: no trigger before cycle 64 of WAIT_TRIG; the next sample is written to addr 0 = 0x100; auto_trig=1 with frame_done.
- Bursty FIFO:
  - Setup: writer inserts random 0–5 cycle empty gaps.
  - Required: fifo_rd is never high while fifo_empty is high; exactly FRAME_LEN fb_we pulses; addresses 0..255 in order; no extra FIFO read after the last sample (FIFO content count checked).
- Reset mid-capture:
  - Setup: assert rst at fb_addr=100.
  - Required: the next cycle shows all outputs 0 and state IDLE.
  - Then: FIFO data without an arm causes no fifo_rd; a new arm yields a full valid frame.
- DONE handshake:
  - Setup: after frame_done, pulse arm.
  - Required: no effect, frame_done stays 1.
  - Then: frame_ack -> frame_done=0 next cycle; a subsequent arm restarts WAIT_TRIG.
